// File: rtl/range_scan_scheduler.sv
// Round-robin scheduler that shares one range classifier across NUM_CH channels,
// debounces each channel's range code and reports committed changes over valid/ready.
module range_scan_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DWELL  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_CH*7-1:0]       ch_level,
  output logic [6:0]                class_number,
  input  logic [1:0]                class_bits,
  output logic [NUM_CH*2-1:0]       ch_range,
  output logic                      change_valid,
  input  logic                      change_ready,
  output logic [$clog2(NUM_CH)-1:0] change_ch,
  output logic [1:0]                change_range,
  output logic                      err
);

  localparam int PW = $clog2(NUM_CH);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);
  localparam logic [PW-1:0] LAST_C  = PW'(NUM_CH - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [1:0]    range_q [NUM_CH];
  logic [1:0]    range_d [NUM_CH];
  logic [1:0]    cand_q  [NUM_CH];
  logic [1:0]    cand_d  [NUM_CH];
  logic [CW-1:0] cnt_q   [NUM_CH];
  logic [CW-1:0] cnt_d   [NUM_CH];
  logic          vld_q, vld_d;
  logic [PW-1:0] ch_q, ch_d;
  logic [1:0]    rng_q, rng_d;
  logic          err_q, err_d;

  logic [6:0]    lvl [NUM_CH];
  logic          eval_fire;
  logic          commit;
  logic [CW-1:0] cnt_new;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign lvl[c]            = ch_level[7*c +: 7];
    assign ch_range[2*c +: 2] = range_q[c];
  end

  assign class_number = lvl[ptr_q];
  assign change_valid = vld_q;
  assign change_ch    = ch_q;
  assign change_range = rng_q;
  assign err          = err_q;

  // A held event blocks evaluation, so the scan stalls instead of dropping events.
  always_comb begin
    eval_fire = en && (!vld_q || change_ready);
    ptr_d     = ptr_q;
    range_d   = range_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    commit    = 1'b0;
    cnt_new   = '0;
    if (eval_fire) begin
      ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + PW'(1);
      if (class_bits == 2'b11) begin
        err_d = 1'b1;
      end else begin
        if (class_bits == range_q[ptr_q]) begin
          cnt_new = '0;
        end else if (class_bits != cand_q[ptr_q]) begin
          cnt_new = CW'(1);
        end else begin
          cnt_new = cnt_q[ptr_q] + CW'(1);
        end
        cand_d[ptr_q] = class_bits;
        if (cnt_new == DWELL_C) begin
          commit         = 1'b1;
          range_d[ptr_q] = class_bits;
          cnt_d[ptr_q]   = '0;
        end else begin
          cnt_d[ptr_q]   = cnt_new;
        end
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    ch_d  = ch_q;
    rng_d = rng_q;
    if (commit) begin
      vld_d = 1'b1;
      ch_d  = ptr_q;
      rng_d = class_bits;
    end else if (vld_q && change_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        range_q[c] <= 2'b00;
        cand_q[c]  <= 2'b00;
        cnt_q[c]   <= '0;
      end
      vld_q <= 1'b0;
      ch_q  <= '0;
      rng_q <= 2'b00;
      err_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      range_q <= range_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ch_q    <= ch_d;
      rng_q   <= rng_d;
      err_q   <= err_d;
    end
  end

endmodule
